lane_tx_gearbox: RTL and testbench
==================================

# lane_tx_gearbox

Transmit gearbox placed directly downstream of the 64b/66b / 128b/132b encoding stage. It accepts one encoded word per lane per strobe, at 66 bits for Gen2, 132 bits for Gen1 or 8 bits for Gen0 bypass. It repacks the bitstream into fixed 8-bit symbols per lane for the serializer, preserving exact bit order across word boundaries. Lanes 0 and 1 are processed in lockstep with a shared fill count.

## Interface
Parameters:
- OUT_W, 8, output symbol width per lane in bits (fixed at 8 for this block).
- BUF_W, 272, per-lane bit-buffer capacity (two 132-bit words plus one symbol).

Ports:
- enc_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  synchronous clear when low; flushes buffer, clears flags and outputs.
- gen_speed  in  2  word format: 2 = 66-bit, 1 = 132-bit, 0 = 8-bit bypass, 3 = reserved (treated as 0).
- enc_valid  in  1  one-cycle strobe; the encoded words are new this cycle.
- lane_0_enc  in  132  lane 0 encoded word, format {sync, data}, right-aligned (66-bit: sync in [65:64]; 132-bit: sync in [131:128]; 8-bit: [7:0]).
- lane_1_enc  in  132  lane 1 encoded word, same format.
- lane_0_sym  out  8  lane 0 output symbol; bit 0 is transmitted first.
- lane_1_sym  out  8  lane 1 output symbol.
- sym_valid  out  1  symbols valid this cycle.
- ovf  out  1  sticky overflow flag.

## Operation
- Word length L = 66 / 132 / 8 per gen_speed, sampled only on enc_valid cycles.
- Transmit order per word: sync field first, LSB first, then data LSB first. For Gen0 there is no sync field and bits [7:0] go out LSB first.
- Internal state per lane: bit buffer buf[BUF_W-1:0], with the oldest bit at buf[0]. Shared fill counter is 9 bits, range 0..BUF_W.
- Each cycle, in this order:
  - Pop: if fill ≥ 8, register buf[7:0] to *_sym, set sym_valid = 1, shift buf right by 8, and reduce fill by 8. Otherwise sym_valid = 0 and *_sym = 0.
  - Push: if enc_valid, append the reordered word at bit position fill_after_pop, then fill += L.
- Overflow: if fill_after_pop + L > BUF_W on a push, drop the word on both lanes, set ovf = 1, and leave fill unchanged. ovf clears only on reset or enable low.
- Residual bits below 8 stay in the buffer and are prepended to the next word. There is no padding and no timeout flush.
- enable low: fill = 0, buffer contents are don't-care, all outputs 0. The enc_valid strobe is ignored in that cycle.
- A gen_speed change with residual bits present is an integration error. The block does not detect it; residual bits are emitted as-is before the new-format bits.

## Timing
- Reset values: lane_0_sym = 0, lane_1_sym = 0, sym_valid = 0, ovf = 0, fill = 0.
- Latency: a word pushed into an empty buffer at edge N produces its first symbol at edge N+1. Outputs are registered.
- Pop and push in the same cycle are legal. The pop uses the buffer state before the push.
- Steady state, Gen2 at one word per 9 cycles: 66 bits in, up to 72 bits out. Bubbles in sym_valid are expected and are not an error.
- Back-to-back enc_valid with L = 132: fill peaks at 132 + 132 − 8 = 256 ≤ 272, so there is no overflow. A third consecutive 132-bit word overflows.
- An asynchronous reset mid-word discards all buffered bits immediately.

## Test plan
- Gen2 single word: data = 64'h0123456789ABCDEF, sync = 2'b10. Required: sym_valid high for 8 consecutive cycles, first lane_0_sym = 8'hBE, second = 8'h37. Then sym_valid drops with fill = 2.
- Gen2 residual chaining: a second 66-bit word 9 cycles later. Required: the first symbol equals {word2 bits[5:0], residual 2 bits}, and fill returns to 4 after 8 more symbols.
- Gen1 back-to-back: three consecutive enc_valid of 132 bits. Required: the first two are accepted and the third is dropped with ovf = 1. The following symbols reproduce words 1 and 2 exactly (33 symbols).
- Gen0 bypass: lane_0_enc[7:0] = 8'hA5, lane_1_enc[7:0] = 8'h3C. Required: the next cycle has lane_0_sym = 8'hA5, lane_1_sym = 8'h3C, sym_valid = 1.
- enable low mid-stream: drop enable while fill = 40. Required: next cycle sym_valid = 0, outputs 0, ovf = 0. After re-enable, the next word emits from bit 0 with no stale bits.
- Async reset: assert rst during active output. Required: all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/lane_tx_gearbox_if.sv
// Encoder-to-gearbox bus: encoded words in, 8-bit symbols out.
// master = word source / symbol sink, slave = gearbox.
interface lane_tx_gearbox_if;
  logic         enable;
  logic [1:0]   gen_speed;
  logic         enc_valid;
  logic [131:0] lane_0_enc;
  logic [131:0] lane_1_enc;
  logic [7:0]   lane_0_sym;
  logic [7:0]   lane_1_sym;
  logic         sym_valid;
  logic         ovf;

  modport master (
    output enable, gen_speed, enc_valid,
    output lane_0_enc, lane_1_enc,
    input  lane_0_sym, lane_1_sym,
    input  sym_valid, ovf
  );

  modport slave (
    input  enable, gen_speed, enc_valid,
    input  lane_0_enc, lane_1_enc,
    output lane_0_sym, lane_1_sym,
    output sym_valid, ovf
  );
endinterface

// File: rtl/lane_tx_gearbox.sv
// Two-lane TX gearbox: repacks 66/132/8-bit encoded words into 8-bit symbols.
// Ports: enc_clk, rst (async, active-low), bus (slave modport of the gearbox bus).
module lane_tx_gearbox #(
  parameter int OUT_W = 8,
  parameter int BUF_W = 272
) (
  input  logic               enc_clk,
  input  logic               rst,
  lane_tx_gearbox_if.slave   bus
);

  logic [BUF_W-1:0] sb0_q, sb0_d;
  logic [BUF_W-1:0] sb1_q, sb1_d;
  logic [8:0]       fill_q, fill_d;
  logic [OUT_W-1:0] sym0_q, sym0_d;
  logic [OUT_W-1:0] sym1_q, sym1_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  logic [131:0]     r0, r1;
  logic [8:0]       len;
  logic [8:0]       fill_ap;
  logic [9:0]       sum;
  logic             pop, push, fits;
  logic [BUF_W-1:0] sh0, sh1;

  always_comb begin
    r0  = '0;
    r1  = '0;
    len = 9'd8;
    // Reorder so transmit order is LSB-first: sync field, then data.
    case (bus.gen_speed)
      2'd2: begin
        len = 9'd66;
        r0  = {66'd0, bus.lane_0_enc[63:0],
               bus.lane_0_enc[65:64]};
        r1  = {66'd0, bus.lane_1_enc[63:0],
               bus.lane_1_enc[65:64]};
      end
      2'd1: begin
        len = 9'd132;
        r0  = {bus.lane_0_enc[127:0],
               bus.lane_0_enc[131:128]};
        r1  = {bus.lane_1_enc[127:0],
               bus.lane_1_enc[131:128]};
      end
      default: begin
        len = 9'd8;
        r0  = {124'd0, bus.lane_0_enc[7:0]};
        r1  = {124'd0, bus.lane_1_enc[7:0]};
      end
    endcase

    pop     = fill_q >= 9'(OUT_W);
    fill_ap = pop ? fill_q - 9'(OUT_W) : fill_q;
    sh0     = pop ? sb0_q >> OUT_W : sb0_q;
    sh1     = pop ? sb1_q >> OUT_W : sb1_q;
    sum     = {1'b0, fill_ap} + {1'b0, len};
    fits    = sum <= 10'(BUF_W);
    push    = bus.enc_valid && fits;

    // Bits above fill are kept zero, so a plain OR appends the word.
    sb0_d  = sh0;
    sb1_d  = sh1;
    fill_d = fill_ap;
    if (push) begin
      sb0_d  = sh0 | (BUF_W'(r0) << fill_ap);
      sb1_d  = sh1 | (BUF_W'(r1) << fill_ap);
      fill_d = sum[8:0];
    end

    sym0_d = pop ? sb0_q[OUT_W-1:0] : '0;
    sym1_d = pop ? sb1_q[OUT_W-1:0] : '0;
    vld_d  = pop;
    ovf_d  = ovf_q | (bus.enc_valid && !fits);

    if (!bus.enable) begin
      sb0_d  = '0;
      sb1_d  = '0;
      fill_d = '0;
      sym0_d = '0;
      sym1_d = '0;
      vld_d  = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      sb0_q  <= '0;
      sb1_q  <= '0;
      fill_q <= '0;
      sym0_q <= '0;
      sym1_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sb0_q  <= sb0_d;
      sb1_q  <= sb1_d;
      fill_q <= fill_d;
      sym0_q <= sym0_d;
      sym1_q <= sym1_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.lane_0_sym = sym0_q;
  assign bus.lane_1_sym = sym1_q;
  assign bus.sym_valid  = vld_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_lane_tx_gearbox.sv
// Directed bench for lane_tx_gearbox: vector table plus
// hand-written multi-cycle sequences.
module tb_lane_tx_gearbox;

  logic enc_clk = 1'b0;
  logic rst     = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  bit   q0[$];
  bit   q1[$];

  always #5 enc_clk = ~enc_clk;

  lane_tx_gearbox_if bus ();

  lane_tx_gearbox #(
    .OUT_W (8),
    .BUF_W (272)
  ) dut (
    .enc_clk (enc_clk),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    logic         en;
    logic [1:0]   gen;
    logic         vld;
    logic [131:0] l0;
    logic [131:0] l1;
    logic [7:0]   e0;
    logic [7:0]   e1;
    logic         ev;
    logic         eovf;
  } vec_t;

  vec_t tv[7];

  localparam logic [131:0] W1A =
    {4'hA, 128'h00112233445566778899AABBCCDDEEFF};
  localparam logic [131:0] W1B =
    {4'h5, 128'hDEADBEEF0BADF00D1234567890ABCDEF};
  localparam logic [131:0] W2A =
    {4'h3, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F};
  localparam logic [131:0] W2B =
    {4'hC, 128'h13579BDF2468ACE00FEDCBA987654321};
  localparam logic [131:0] W3A =
    {4'hF, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF};

  task automatic step();
    @(posedge enc_clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [131:0] w0,
                           input logic [131:0] w1,
                           input logic [1:0]   g);
    int sb, sw, dw;
    if (g == 2'd2) begin
      sb = 64; sw = 2; dw = 64;
    end else if (g == 2'd1) begin
      sb = 128; sw = 4; dw = 128;
    end else begin
      sb = 0; sw = 0; dw = 8;
    end
    for (int i = 0; i < sw; i++) begin
      q0.push_back(w0[sb+i]);
      q1.push_back(w1[sb+i]);
    end
    for (int i = 0; i < dw; i++) begin
      q0.push_back(w0[i]);
      q1.push_back(w1[i]);
    end
  endtask

  task automatic expect_sym(input string nm);
    logic [7:0] e0, e1;
    chk({nm, "_v"}, bus.sym_valid, 1);
    if (q0.size() < 8) begin
      chk({nm, "_qbits"}, q0.size(), 8);
    end else begin
      for (int j = 0; j < 8; j++) begin
        e0[j] = q0.pop_front();
        e1[j] = q1.pop_front();
      end
      chk({nm, "_l0"}, bus.lane_0_sym, e0);
      chk({nm, "_l1"}, bus.lane_1_sym, e1);
    end
  endtask

  task automatic clear_state();
    bus.enable    = 1'b0;
    bus.enc_valid = 1'b0;
    step();
    bus.enable = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  task automatic drive(input logic [1:0]   g,
                       input logic         v,
                       input logic [131:0] a,
                       input logic [131:0] b);
    bus.gen_speed  = g;
    bus.enc_valid  = v;
    bus.lane_0_enc = a;
    bus.lane_1_enc = b;
  endtask

  initial begin
    tv[0] = '{1'b1, 2'd0, 1'b1, {124'hABC, 8'hA5},
              {124'h123, 8'h3C}, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[1] = '{1'b1, 2'd0, 1'b1, {124'h9, 8'h5A},
              {124'hE, 8'hC3}, 8'hA5, 8'h3C, 1'b1, 1'b0};
    tv[2] = '{1'b1, 2'd3, 1'b1, {124'h5, 8'hFF},
              {124'h7, 8'h00}, 8'h5A, 8'hC3, 1'b1, 1'b0};
    tv[3] = '{1'b1, 2'd0, 1'b0, 132'd0,
              132'd0, 8'hFF, 8'h00, 1'b1, 1'b0};
    tv[4] = '{1'b1, 2'd0, 1'b0, 132'd0,
              132'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[5] = '{1'b0, 2'd0, 1'b1, {124'h1, 8'h12},
              {124'h2, 8'h34}, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[6] = '{1'b1, 2'd0, 1'b0, 132'd0,
              132'd0, 8'h00, 8'h00, 1'b0, 1'b0};

    bus.enable = 1'b0;
    drive(2'd0, 1'b0, '0, '0);
    #12;
    chk("reset_out",
        {bus.ovf, bus.sym_valid,
         bus.lane_1_sym, bus.lane_0_sym}, 0);
    rst = 1'b1;
    step();
    bus.enable = 1'b1;
    step();
    chk("reset_idle", bus.sym_valid, 0);

    // Gen0 / reserved / enable-low vector table
    for (int i = 0; i < 7; i++) begin
      bus.enable = tv[i].en;
      drive(tv[i].gen, tv[i].vld, tv[i].l0, tv[i].l1);
      step();
      chk($sformatf("vec%0d", i),
          {bus.ovf, bus.sym_valid,
           bus.lane_1_sym, bus.lane_0_sym},
          {tv[i].eovf, tv[i].ev, tv[i].e1, tv[i].e0});
    end
    bus.enable = 1'b1;
    bus.enc_valid = 1'b0;

    // Gen2 single word, then residual chaining
    clear_state();
    drive(2'd2, 1'b1,
          {66'd0, 2'b10, 64'h0123456789ABCDEF},
          {66'd0, 2'b01, 64'hFEDCBA9876543210});
    push_word(bus.lane_0_enc, bus.lane_1_enc, 2'd2);
    step();
    bus.enc_valid = 1'b0;
    chk("g2_latency", bus.sym_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) chk("g2_first", bus.lane_0_sym, 8'hBE);
      if (i == 1) chk("g2_second", bus.lane_0_sym, 8'h37);
      expect_sym($sformatf("g2_s%0d", i));
    end
    drive(2'd2, 1'b1,
          {66'd0, 2'b01, 64'hFFFF0000AAAA1234},
          {66'd0, 2'b11, 64'h0F0F0F0F0F0F0F0F});
    push_word(bus.lane_0_enc, bus.lane_1_enc, 2'd2);
    step();
    bus.enc_valid = 1'b0;
    chk("g2_gap", bus.sym_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) chk("g2_chain", bus.lane_0_sym, 8'h44);
      expect_sym($sformatf("g2_c%0d", i));
    end
    drive(2'd0, 1'b1, {124'd0, 8'h5A}, {124'd0, 8'h00});
    push_word(bus.lane_0_enc, bus.lane_1_enc, 2'd0);
    step();
    bus.enc_valid = 1'b0;
    chk("g2_tail_gap", bus.sym_valid, 0);
    step();
    chk("g2_fill4", bus.lane_0_sym, 8'hAF);
    expect_sym("g2_tail");
    step();
    chk("g2_tail_end", bus.sym_valid, 0);

    // Gen1 back-to-back, third word overflows
    clear_state();
    drive(2'd1, 1'b1, W1A, W1B);
    push_word(W1A, W1B, 2'd1);
    step();
    chk("g1_w1", {bus.ovf, bus.sym_valid}, 0);
    drive(2'd1, 1'b1, W2A, W2B);
    push_word(W2A, W2B, 2'd1);
    step();
    chk("g1_w2_ovf", bus.ovf, 0);
    chk("g1_first", bus.lane_0_sym, 8'hFA);
    expect_sym("g1_s0");
    drive(2'd1, 1'b1, W3A, W3A);
    step();
    bus.enc_valid = 1'b0;
    chk("g1_ovf", bus.ovf, 1);
    expect_sym("g1_s1");
    for (int i = 2; i < 33; i++) begin
      step();
      expect_sym($sformatf("g1_s%0d", i));
    end
    step();
    chk("g1_end", {bus.ovf, bus.sym_valid}, 2'b10);
    bus.enable = 1'b0;
    step();
    chk("en_ovf_clr", bus.ovf, 0);
    bus.enable = 1'b1;
    q0.delete();
    q1.delete();

    // enable low while 40 bits are buffered
    drive(2'd1, 1'b1, W1A, W1B);
    push_word(W1A, W1B, 2'd1);
    step();
    drive(2'd1, 1'b1, W2A, W2B);
    push_word(W2A, W2B, 2'd1);
    step();
    bus.enc_valid = 1'b0;
    expect_sym("en_s0");
    for (int i = 1; i < 28; i++) begin
      step();
      expect_sym($sformatf("en_s%0d", i));
    end
    bus.enable = 1'b0;
    drive(2'd0, 1'b1, {124'd0, 8'hFF}, {124'd0, 8'hFF});
    step();
    chk("en_low_out",
        {bus.ovf, bus.sym_valid,
         bus.lane_1_sym, bus.lane_0_sym}, 0);
    bus.enable = 1'b1;
    bus.enc_valid = 1'b0;
    q0.delete();
    q1.delete();
    step();
    chk("en_strobe_ign", bus.sym_valid, 0);
    drive(2'd0, 1'b1, {124'd0, 8'hC3}, {124'd0, 8'h81});
    step();
    bus.enc_valid = 1'b0;
    step();
    chk("en_fresh",
        {bus.sym_valid, bus.lane_1_sym, bus.lane_0_sym},
        {1'b1, 8'h81, 8'hC3});
    step();

    // async reset while symbols stream, ovf set
    drive(2'd1, 1'b1, W1A, W1B);
    step();
    drive(2'd1, 1'b1, W2A, W2B);
    step();
    drive(2'd1, 1'b1, W3A, W3A);
    step();
    bus.enc_valid = 1'b0;
    step();
    chk("rst_pre", {bus.ovf, bus.sym_valid}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("rst_async",
        {bus.ovf, bus.sym_valid,
         bus.lane_1_sym, bus.lane_0_sym}, 0);
    #3 rst = 1'b1;
    step();
    chk("rst_discard1", {bus.ovf, bus.sym_valid}, 0);
    step();
    chk("rst_discard2", {bus.ovf, bus.sym_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
